// File: rtl/output_buffer_pkg.sv
// Shared definitions for the output buffer controller: FSM states,
// pending-load mode encodings and the default mapping-group count.
package output_buffer_pkg;

    // Number of 32-bit mapping groups unloaded per compute result.
    localparam int NUM_GROUPS = 32;

    // Controller sequencing states.
    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WAIT_FLASH = 3'd1,
        ST_WR0        = 3'd2,
        ST_WR1        = 3'd3,
        ST_WR2        = 3'd4,
        ST_ZP         = 3'd5,
        ST_LOAD       = 3'd6,
        ST_DONE       = 3'd7
    } state_e;

    // Pending load mode reported on before_load_mode_o.
    localparam logic [1:0] BLM_NONE   = 2'd0;
    localparam logic [1:0] BLM_READ   = 2'd1;
    localparam logic [1:0] BLM_PIM    = 2'd2;
    localparam logic [1:0] BLM_PIM_ZP = 2'd3;

    // A requested bit-iteration count of 0 stands for the full 8 iterations.
    function automatic logic [3:0] eff_bits(input logic [3:0] n);
        return (n == 4'd0) ? 4'd8 : n;
    endfunction

endpackage

// File: rtl/output_buffer_ctrl.sv
// Output buffer controller: sequences eFlash results into the output
// buffers (read path or bit-serial compute path with optional zero point)
// and then serves RISC-V load requests, one beat per mapping group.
module output_buffer_ctrl #(
    parameter int NUM_GROUPS = output_buffer_pkg::NUM_GROUPS
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic [2:0] pim_mode_i,
    input  logic [3:0] num_bits_i,
    input  logic       zp_cfg_i,
    input  logic       flash_valid_i,
    input  logic       load_req_i,
    output logic       buf_write_en_0_o,
    output logic       buf_write_en_1_o,
    output logic       buf_write_en_2_o,
    output logic       buf_read_en_o,
    output logic       shift_counter_en_o,
    output logic       zero_point_en_o,
    output logic       load_en_o,
    output logic [5:0] load_cnt_o,
    output logic [1:0] before_load_mode_o,
    output logic       load_valid_o,
    output logic       load_last_o,
    output logic       busy_o,
    output logic       done_o
);
    import output_buffer_pkg::*;

    // Final load index in compute mode; read mode always unloads a single beat.
    localparam logic [5:0] LAST_PIM_IDX = 6'(NUM_GROUPS - 1);

    state_e     state_q, state_d;
    logic       compute_q, compute_d;
    logic [3:0] nbits_q, nbits_d;
    logic       zp_q, zp_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [5:0] load_idx_q, load_idx_d;
    logic [1:0] bl_mode_q, bl_mode_d;
    logic       load_valid_q, load_valid_d;
    logic       load_last_q, load_last_d;

    logic [3:0] bit_cnt_inc;
    logic [5:0] last_idx;
    logic       load_fire;
    logic       at_last;

    assign bit_cnt_inc = bit_cnt_q + 4'd1;
    assign last_idx    = compute_q ? LAST_PIM_IDX : 6'd0;
    assign load_fire   = (state_q == ST_LOAD) && load_req_i;
    assign at_last     = (load_idx_q == last_idx);

    // Next-state, counter and latched-configuration logic.
    always_comb begin
        // NOTE: every signal gets a hold default first so no path can infer a latch.
        state_d      = state_q;
        compute_d    = compute_q;
        nbits_d      = nbits_q;
        zp_d         = zp_q;
        bit_cnt_d    = bit_cnt_q;
        load_idx_d   = load_idx_q;
        bl_mode_d    = bl_mode_q;
        // The output buffer registers its select, so valid/last trail the load by one cycle.
        load_valid_d = load_fire;
        load_last_d  = load_fire && at_last;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d    = ST_WAIT_FLASH;
                    compute_d  = |pim_mode_i;
                    nbits_d    = eff_bits(num_bits_i);
                    zp_d       = zp_cfg_i;
                    bit_cnt_d  = 4'd0;
                    load_idx_d = 6'd0;
                end
            end
            ST_WAIT_FLASH: begin
                if (flash_valid_i) begin
                    state_d = compute_q ? ST_WR1 : ST_WR0;
                end
            end
            ST_WR0: begin
                state_d   = ST_LOAD;
                bl_mode_d = BLM_READ;
            end
            ST_WR1: begin
                state_d = ST_WR2;
            end
            ST_WR2: begin
                bit_cnt_d = bit_cnt_inc;
                if (bit_cnt_inc < nbits_q) begin
                    state_d = ST_WAIT_FLASH;
                end else if (zp_q) begin
                    state_d = ST_ZP;
                end else begin
                    state_d   = ST_LOAD;
                    bl_mode_d = BLM_PIM;
                end
            end
            ST_ZP: begin
                state_d   = ST_LOAD;
                bl_mode_d = BLM_PIM_ZP;
            end
            ST_LOAD: begin
                if (load_req_i) begin
                    // The index parks on the final beat instead of wrapping.
                    if (at_last) begin
                        state_d = ST_DONE;
                    end else begin
                        load_idx_d = load_idx_q + 6'd1;
                    end
                end
            end
            ST_DONE: begin
                state_d    = ST_IDLE;
                bl_mode_d  = BLM_NONE;
                load_idx_d = 6'd0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; reset returns everything to idle immediately.
    always_ff @(posedge clk_i or posedge rst_i) begin
        // NOTE: non-blocking assignments keep all flops updating from pre-edge values.
        if (rst_i) begin
            state_q      <= ST_IDLE;
            compute_q    <= 1'b0;
            nbits_q      <= 4'd0;
            zp_q         <= 1'b0;
            bit_cnt_q    <= 4'd0;
            load_idx_q   <= 6'd0;
            bl_mode_q    <= BLM_NONE;
            load_valid_q <= 1'b0;
            load_last_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            compute_q    <= compute_d;
            nbits_q      <= nbits_d;
            zp_q         <= zp_d;
            bit_cnt_q    <= bit_cnt_d;
            load_idx_q   <= load_idx_d;
            bl_mode_q    <= bl_mode_d;
            load_valid_q <= load_valid_d;
            load_last_q  <= load_last_d;
        end
    end

    // Strobes decode straight from the registered state, so reset clears them at once.
    assign buf_write_en_0_o   = (state_q == ST_WR0);
    assign buf_write_en_1_o   = (state_q == ST_WR1);
    assign buf_write_en_2_o   = (state_q == ST_WR2);
    assign shift_counter_en_o = (state_q == ST_WR2);
    assign zero_point_en_o    = (state_q == ST_ZP);
    assign load_en_o          = load_fire;
    assign buf_read_en_o      = load_fire && compute_q;
    assign load_cnt_o         = load_idx_q;
    assign before_load_mode_o = bl_mode_q;
    assign load_valid_o       = load_valid_q;
    assign load_last_o        = load_last_q;
    assign busy_o             = (state_q != ST_IDLE);
    assign done_o             = (state_q == ST_DONE);

endmodule

// File: tb/tb_output_buffer_ctrl.sv
// Self-checking bench for output_buffer_ctrl. Each sequence is described up
// front as a list of cycles (inputs plus expected outputs) derived from the
// controller's behavioural rules, then played against the DUT.
module tb_output_buffer_ctrl;

    localparam int NG = 32;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b0;
    logic       start_i = 1'b0;
    logic [2:0] pim_mode_i = 3'd0;
    logic [3:0] num_bits_i = 4'd0;
    logic       zp_cfg_i = 1'b0;
    logic       flash_valid_i = 1'b0;
    logic       load_req_i = 1'b0;
    logic       buf_write_en_0_o, buf_write_en_1_o, buf_write_en_2_o;
    logic       buf_read_en_o, shift_counter_en_o, zero_point_en_o;
    logic       load_en_o;
    logic [5:0] load_cnt_o;
    logic [1:0] before_load_mode_o;
    logic       load_valid_o, load_last_o, busy_o, done_o;

    output_buffer_ctrl #(.NUM_GROUPS(NG)) dut (
        .clk_i              (clk_i),
        .rst_i              (rst_i),
        .start_i            (start_i),
        .pim_mode_i         (pim_mode_i),
        .num_bits_i         (num_bits_i),
        .zp_cfg_i           (zp_cfg_i),
        .flash_valid_i      (flash_valid_i),
        .load_req_i         (load_req_i),
        .buf_write_en_0_o   (buf_write_en_0_o),
        .buf_write_en_1_o   (buf_write_en_1_o),
        .buf_write_en_2_o   (buf_write_en_2_o),
        .buf_read_en_o      (buf_read_en_o),
        .shift_counter_en_o (shift_counter_en_o),
        .zero_point_en_o    (zero_point_en_o),
        .load_en_o          (load_en_o),
        .load_cnt_o         (load_cnt_o),
        .before_load_mode_o (before_load_mode_o),
        .load_valid_o       (load_valid_o),
        .load_last_o        (load_last_o),
        .busy_o             (busy_o),
        .done_o             (done_o)
    );

    always #5 clk_i = ~clk_i;

    // Observable outputs (load_cnt_o is checked separately).
    typedef struct packed {
        logic       busy, we0, we1, we2, sh, zp, ld, rd;
        logic [1:0] bl;
        logic       lv, ll, done;
    } obs_t;

    // One cycle of stimulus plus its expected response.
    typedef struct packed {
        logic       st, fv, lr;
        logic [2:0] pim;
        logic [3:0] nb;
        logic       zp;
        obs_t       e;
        logic       chk_cnt;
        logic [5:0] cnt;
    } cyc_t;

    cyc_t q[$];
    bit   pend_lv, pend_ll;
    int   n_cmp = 0;
    int   n_err = 0;
    obs_t obs;

    function automatic obs_t sample();
        obs_t o;
        o = {busy_o, buf_write_en_0_o, buf_write_en_1_o, buf_write_en_2_o,
             shift_counter_en_o, zero_point_en_o, load_en_o, buf_read_en_o,
             before_load_mode_o, load_valid_o, load_last_o, done_o};
        return o;
    endfunction

    // A busy-state cycle: every input the controller must ignore gets random noise.
    function automatic cyc_t new_cyc(input bit noise);
        cyc_t d;
        d = '0;
        d.st  = noise ? 1'($urandom()) : 1'b0;
        d.fv  = noise ? 1'($urandom()) : 1'b0;
        d.lr  = noise ? 1'($urandom()) : 1'b0;
        d.pim = 3'($urandom());
        d.nb  = 4'($urandom());
        d.zp  = 1'($urandom());
        d.e.busy = 1'b1;
        return d;
    endfunction

    // Append a cycle; valid/last/done are the echo of the previous cycle's load.
    task automatic push(input cyc_t d, input bit acc, input bit last);
        d.e.lv   = pend_lv;
        d.e.ll   = pend_ll;
        d.e.done = pend_ll;
        q.push_back(d);
        pend_lv = acc;
        pend_ll = acc && last;
    endtask

    // Reference model: expand one full sequence into per-cycle expectations.
    task automatic build_seq(input logic [2:0] pim, input logic [3:0] nb, input logic zp,
                             input int gmin, input int gmax, input bit noise);
        cyc_t       d;
        bit         compute;
        int         bits, beats, g;
        logic [1:0] blm;
        q.delete();
        pend_lv = 0;
        pend_ll = 0;
        compute = (pim != 3'd0);
        bits    = !compute ? 1 : (nb == 4'd0 ? 8 : int'(nb));
        beats   = compute ? NG : 1;
        blm     = !compute ? 2'd1 : (zp ? 2'd3 : 2'd2);

        d = new_cyc(noise);
        d.st = 1'b1; d.pim = pim; d.nb = nb; d.zp = zp;
        d.e = '0;
        push(d, 0, 0);

        for (int b = 0; b < bits; b++) begin
            g = int'($urandom_range(2, 0));
            for (int k = 0; k < g; k++) begin
                d = new_cyc(noise); d.fv = 1'b0;
                push(d, 0, 0);
            end
            d = new_cyc(noise); d.fv = 1'b1;
            push(d, 0, 0);
            if (!compute) begin
                d = new_cyc(noise); d.e.we0 = 1'b1;
                push(d, 0, 0);
            end else begin
                d = new_cyc(noise); d.e.we1 = 1'b1;
                push(d, 0, 0);
                d = new_cyc(noise); d.e.we2 = 1'b1; d.e.sh = 1'b1;
                push(d, 0, 0);
            end
        end
        if (compute && zp) begin
            d = new_cyc(noise); d.e.zp = 1'b1;
            push(d, 0, 0);
        end

        for (int k = 0; k < beats; k++) begin
            g = int'($urandom_range(gmax, gmin));
            for (int j = 0; j < g; j++) begin
                d = new_cyc(noise); d.lr = 1'b0; d.e.bl = blm;
                d.chk_cnt = 1'b1; d.cnt = 6'(k);
                push(d, 0, 0);
            end
            d = new_cyc(noise); d.lr = 1'b1; d.e.bl = blm;
            d.e.ld = 1'b1; d.e.rd = compute;
            d.chk_cnt = 1'b1; d.cnt = 6'(k);
            push(d, 1, k == beats - 1);
        end

        d = new_cyc(noise); d.e.bl = blm;
        push(d, 0, 0);
        d = new_cyc(noise); d.st = 1'b0; d.e = '0;
        push(d, 0, 0);
    endtask

    // Play the first 'limit' cycles of the current sequence against the DUT.
    task automatic run_queue(input int limit);
        for (int i = 0; i < limit; i++) begin
            @(posedge clk_i); #1;
            start_i = q[i].st; flash_valid_i = q[i].fv; load_req_i = q[i].lr;
            pim_mode_i = q[i].pim; num_bits_i = q[i].nb; zp_cfg_i = q[i].zp;
            @(negedge clk_i);
            obs = sample();
            n_cmp++;
            if (obs !== q[i].e) begin
                n_err++;
                $display("FAIL seq_cycle %0d outputs: got %b want %b (busy,we0,we1,we2,sh,zp,ld,rd,bl,lv,ll,done)",
                         i, obs, q[i].e);
            end
            if (q[i].chk_cnt) begin
                n_cmp++;
                if (load_cnt_o !== q[i].cnt) begin
                    n_err++;
                    $display("FAIL seq_cycle %0d load_cnt: got %0d want %0d", i, load_cnt_o, q[i].cnt);
                end
            end
        end
    endtask

    task automatic quiet_inputs();
        start_i = 0; flash_valid_i = 0; load_req_i = 0;
        pim_mode_i = 0; num_bits_i = 0; zp_cfg_i = 0;
    endtask

    task automatic test_reset();
        #1 rst_i = 1'b1;
        #1;
        n_cmp++;
        if (sample() !== obs_t'('0) || load_cnt_o !== 6'd0) begin
            n_err++;
            $display("FAIL reset_state: got %b cnt %0d want all zero", sample(), load_cnt_o);
        end
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;
        @(negedge clk_i);
        n_cmp++;
        if (sample() !== obs_t'('0)) begin
            n_err++;
            $display("FAIL reset_release: got %b want all zero", sample());
        end
    endtask

    task automatic test_ignored_inputs();
        for (int i = 0; i < 4; i++) begin
            @(posedge clk_i); #1;
            flash_valid_i = 1'(i); load_req_i = 1'b1; start_i = 1'b0;
            @(negedge clk_i);
            n_cmp++;
            if (sample() !== obs_t'('0)) begin
                n_err++;
                $display("FAIL idle_ignore %0d: got %b want all zero", i, sample());
            end
        end
        @(posedge clk_i); #1 quiet_inputs();
    endtask

    task automatic test_read_mode();
        for (int r = 0; r < 2; r++) begin
            build_seq(3'd0, 4'($urandom_range(8, 0)), 1'($urandom()), 0, 0, r == 1);
            run_queue(q.size());
        end
    endtask

    task automatic test_compute_zp();
        build_seq(3'd1, 4'd4, 1'b1, 0, 0, 1'b1);
        run_queue(q.size());
    endtask

    task automatic test_compute_full_bits();
        build_seq(3'($urandom_range(7, 1)), 4'd0, 1'b0, 0, 0, 1'b1);
        run_queue(q.size());
    endtask

    task automatic test_gapped_loads();
        build_seq(3'($urandom_range(7, 1)), 4'($urandom_range(3, 1)), 1'($urandom()), 1, 3, 1'b1);
        run_queue(q.size());
    endtask

    task automatic test_reset_mid_load();
        int idx;
        idx = -1;
        build_seq(3'd2, 4'd2, 1'b1, 0, 1, 1'b1);
        for (int i = 0; i < q.size(); i++) begin
            if (idx < 0 && q[i].e.ld && q[i].cnt == 6'd17) idx = i;
        end
        run_queue(idx + 1);
        #2;
        quiet_inputs();
        rst_i = 1'b1;
        #1;
        n_cmp++;
        if (sample() !== obs_t'('0) || load_cnt_o !== 6'd0) begin
            n_err++;
            $display("FAIL reset_mid_load: got %b cnt %0d want all zero", sample(), load_cnt_o);
        end
        @(posedge clk_i); #1 rst_i = 1'b0;
        repeat (2) begin
            @(negedge clk_i);
            n_cmp++;
            if (sample() !== obs_t'('0)) begin
                n_err++;
                $display("FAIL after_reset_pending: got %b want all zero", sample());
            end
        end
        build_seq(3'd1, 4'($urandom_range(8, 0)), 1'($urandom()), 0, 0, 1'b1);
        run_queue(q.size());
    endtask

    task automatic test_random();
        for (int r = 0; r < 4; r++) begin
            build_seq(3'($urandom_range(7, 0)), 4'($urandom_range(8, 0)), 1'($urandom()),
                      0, 2, 1'b1);
            run_queue(q.size());
        end
    endtask

    initial begin
        test_reset();
        test_ignored_inputs();
        test_read_mode();
        test_compute_zp();
        test_compute_full_bits();
        test_gapped_loads();
        test_reset_mid_load();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
